// File: rtl/pru_frame_writer.sv
// ---------------------------------------------------------------------------
// pru_frame_writer
//   Write-side engine for the 2-bit/pixel frame buffer. Decodes PRU register
//   writes and fills rectangles (or the whole screen) one pixel per cycle
//   through the buffer write port.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pru_frame_writer #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          ADDR_W    = 19,
  parameter logic [31:0] BASE_ADDR = 32'h4010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pru_addr,
  input  logic [31:0]       pru_data,
  input  logic              pru_we,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [1:0]        fb_wrt_data
);

  localparam logic [9:0]        X_MAX    = 10'(H_RES - 1);
  localparam logic [8:0]        Y_MAX    = 9'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // PRU-visible coordinate registers
  logic [9:0] xy0_x, xy1_x;
  logic [8:0] xy0_y, xy1_y;

  // Working copies latched at command accept; clamped in SETUP
  logic [9:0] wk_x0, wk_x1;
  logic [8:0] wk_y0, wk_y1;
  logic [1:0] wk_colour;
  logic       wk_op;

  // Current pixel being presented on the write port
  logic [9:0]        cur_x;
  logic [8:0]        cur_y;
  logic [ADDR_W-1:0] row_base;

  logic sel_xy0, sel_xy1, sel_cmd;
  assign sel_xy0 = pru_we && (pru_addr == BASE_ADDR);
  assign sel_xy1 = pru_we && (pru_addr == BASE_ADDR + 32'd4);
  assign sel_cmd = pru_we && (pru_addr == BASE_ADDR + 32'd8);

  // Bits of the data bus no register field maps onto
  logic unused_data;
  assign unused_data = &{1'b0, pru_data[31:25], pru_data[15:10]};

  // Clamped (or clear-forced) bounds evaluated during SETUP
  logic [9:0]        s_x0, s_x1;
  logic [8:0]        s_y0, s_y1;
  logic [ADDR_W-1:0] s_base;
  logic              s_empty;

  assign s_x0    = wk_op ? 10'd0 : ((wk_x0 > X_MAX) ? X_MAX : wk_x0);
  assign s_x1    = wk_op ? X_MAX : ((wk_x1 > X_MAX) ? X_MAX : wk_x1);
  assign s_y0    = wk_op ? 9'd0  : ((wk_y0 > Y_MAX) ? Y_MAX : wk_y0);
  assign s_y1    = wk_op ? Y_MAX : ((wk_y1 > Y_MAX) ? Y_MAX : wk_y1);
  // Constant multiply; only used once per command, never in the fill loop
  assign s_base  = ADDR_W'(s_y0) * ROW_STEP;
  assign s_empty = (s_x0 > s_x1) || (s_y0 > s_y1);

  // Coordinate registers: writable at any time, independent of the engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xy0_x <= '0;
      xy0_y <= '0;
      xy1_x <= '0;
      xy1_y <= '0;
    end else begin
      if (sel_xy0) begin
        xy0_x <= pru_data[9:0];
        xy0_y <= pru_data[24:16];
      end
      if (sel_xy1) begin
        xy1_x <= pru_data[9:0];
        xy1_y <= pru_data[24:16];
      end
    end
  end

  // Fill engine: command accept, setup, pixel walk and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wrt_data <= '0;
      wk_x0       <= '0;
      wk_x1       <= '0;
      wk_y0       <= '0;
      wk_y1       <= '0;
      wk_colour   <= '0;
      wk_op       <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      row_base    <= '0;
    end else begin
      done <= 1'b0;
      // A command arriving while anything is in flight is dropped and flagged
      if (sel_cmd && (state != IDLE)) begin
        cmd_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sel_cmd) begin
            wk_colour <= pru_data[1:0];
            wk_op     <= pru_data[8];
            wk_x0     <= xy0_x;
            wk_y0     <= xy0_y;
            wk_x1     <= xy1_x;
            wk_y1     <= xy1_y;
            cmd_err   <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          wk_x0 <= s_x0;
          wk_x1 <= s_x1;
          wk_y0 <= s_y0;
          wk_y1 <= s_y1;
          if (s_empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur_x       <= s_x0;
            cur_y       <= s_y0;
            row_base    <= s_base;
            fb_we       <= 1'b1;
            fb_addr     <= s_base + ADDR_W'(s_x0);
            fb_wrt_data <= wk_colour;
            state       <= FILL;
          end
        end
        FILL: begin
          if ((cur_x == wk_x1) && (cur_y == wk_y1)) begin
            fb_we <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cur_x == wk_x1) begin
            // Wrap to the start of the next row; row base advances by adding
            cur_x    <= wk_x0;
            cur_y    <= cur_y + 9'd1;
            row_base <= row_base + ROW_STEP;
            fb_addr  <= row_base + ROW_STEP + ADDR_W'(wk_x0);
          end else begin
            cur_x   <= cur_x + 10'd1;
            fb_addr <= fb_addr + ADDR_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          fb_we <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
